// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer.
// Opcodes are the RV32I major opcodes the sequencer knows how to step.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] PC_SRC_PC4  = 2'd0;
  localparam logic [1:0] PC_SRC_BR   = 2'd1;
  localparam logic [1:0] PC_SRC_JAL  = 2'd2;
  localparam logic [1:0] PC_SRC_JALR = 2'd3;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  function automatic logic op_supported(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR, OP_LUI:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts unanswered memory request cycles and flags when the limit is hit.
// Cleared whenever the sequencer enters a new request state.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear)         cnt_d = '0;
    else if (count_en) cnt_d = cnt_q + 8'd1;
  end

  // Fires in the wait cycle whose increment would reach the limit.
  assign expired = count_en && (cnt_q == LAST);

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle RV32I control sequencer sharing one memory port
// between instruction fetch and load/store.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_is_instr,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        alu_src_b,
  output logic [2:0]  state,
  output logic [31:0] retired,
  output logic        illegal,
  output logic        timeout
);

  state_e      state_q, state_d;
  logic [6:0]  op_q, op_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] retired_q, retired_d;
  logic        illegal_q, illegal_d;
  logic        timeout_q, timeout_d;

  logic expired, tmr_clear, tmr_en;
  logic is_r, is_br, is_load, is_store, is_jal, is_jalr;
  logic br_ok, br_taken;

  assign is_r     = op_q == OP_R;
  assign is_br    = op_q == OP_BRANCH;
  assign is_load  = op_q == OP_LOAD;
  assign is_store = op_q == OP_STORE;
  assign is_jal   = op_q == OP_JAL;
  assign is_jalr  = op_q == OP_JALR;

  assign br_ok    = (f3_q == F3_BEQ) || (f3_q == F3_BNE);
  assign br_taken = (f3_q == F3_BEQ) ? alu_zero : !alu_zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (expired) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end
      end
      S_DECODE: begin
        if (op_supported(opcode)) begin
          state_d = S_EXECUTE;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EXECUTE: begin
        if (is_br) begin
          state_d   = br_ok ? S_FETCH : S_HALT;
          illegal_d = illegal_q | !br_ok;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = is_store ? S_FETCH : S_WB;
        end else if (expired) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_instr = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_PC4;
    reg_write    = 1'b0;
    wb_sel       = WB_SEL_ALU;
    alu_src_b    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req      = 1'b1;
        mem_is_instr = 1'b1;
        ir_write     = mem_ready;
      end
      S_EXECUTE: begin
        alu_src_b = !(is_r || is_br);
        if (is_br && br_ok) begin
          pc_write = 1'b1;
          pc_src   = br_taken ? PC_SRC_BR : PC_SRC_PC4;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = is_store;
        pc_write = is_store && mem_ready;
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        unique case (1'b1)
          is_load:           wb_sel = WB_SEL_MEM;
          is_jal || is_jalr: wb_sel = WB_SEL_PC4;
          default:           wb_sel = WB_SEL_ALU;
        endcase
        unique case (1'b1)
          is_jal:  pc_src = PC_SRC_JAL;
          is_jalr: pc_src = PC_SRC_JALR;
          default: pc_src = PC_SRC_PC4;
        endcase
      end
      default: ;
    endcase
  end

  // Decode fields are captured once so later states ignore IR changes.
  assign op_d      = (state_q == S_DECODE) ? opcode : op_q;
  assign f3_d      = (state_q == S_DECODE) ? func3  : f3_q;
  assign retired_d = retired_q + {31'd0, pc_write};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= '0;
      f3_q      <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      op_q      <= op_d;
      f3_q      <= f3_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign tmr_clear = (state_d != state_q) &&
                     ((state_d == S_FETCH) || (state_d == S_MEM));
  assign tmr_en    = mem_req && !mem_ready;

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .count_en(tmr_en),
    .expired (expired)
  );

  assign state   = state_q;
  assign retired = retired_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: vector table, corner sequences
// and random instructions against a cycle-count model.
module tb_mc_sequencer;
  import mc_pkg::*;

  localparam int T = 8;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111;
  localparam logic [6:0] JR = 7'b1100111;
  localparam logic [6:0] LU = 7'b0110111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = '0;
  logic [2:0]  func3 = '0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_is_instr, ir_write, pc_write;
  logic [1:0]  pc_src, wb_sel;
  logic        reg_write, alu_src_b, illegal, timeout;
  logic [2:0]  state;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  mc_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func3(func3),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .mem_is_instr(mem_is_instr), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .wb_sel(wb_sel), .alu_src_b(alu_src_b), .state(state),
    .retired(retired), .illegal(illegal), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         pcw;
    int         rw;
    int         irw;
    int         we;
    logic [1:0] pcs;
    logic [1:0] wbs;
    logic       ill;
    logic       to;
    logic       asb;
  } exp_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       az;
    int         wf;
    int         wm;
    exp_t       e;
  } vec_t;

  logic [6:0] ops [8] = '{R, I, LD, ST, BR, JL, JR, LU};

  function automatic logic is_sup(input logic [6:0] o);
    for (int i = 0; i < 8; i++) if (ops[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  // Expected totals per instruction from latency and wait rules.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic az, input int wf, input int wm);
    exp_t e;
    e = '{cyc: 0, pcw: 0, rw: 0, irw: 0, we: 0, pcs: 2'd0, wbs: 2'd0,
          ill: 1'b0, to: 1'b0, asb: !(op == R || op == BR)};
    if (wf >= T) begin
      e.cyc = T;
      e.to  = 1'b1;
      return e;
    end
    e.irw = 1;
    if (!is_sup(op)) begin
      e.cyc = wf + 2;
      e.ill = 1'b1;
    end else if (op == BR) begin
      e.cyc = wf + 3;
      if (f3 > 3'd1) begin
        e.ill = 1'b1;
      end else begin
        e.pcw = 1;
        e.pcs = ((f3 == 3'd0) ? az : !az) ? 2'd1 : 2'd0;
      end
    end else if (op == LD || op == ST) begin
      if (wm >= T) begin
        e.cyc = wf + 3 + T;
        e.to  = 1'b1;
        e.we  = (op == ST) ? T : 0;
      end else begin
        e.pcw = 1;
        e.cyc = wf + wm + ((op == LD) ? 5 : 4);
        e.we  = (op == ST) ? wm + 1 : 0;
        if (op == LD) begin
          e.rw  = 1;
          e.wbs = 2'd1;
        end
      end
    end else begin
      e.cyc = wf + 4;
      e.pcw = 1;
      e.rw  = 1;
      e.wbs = (op == JL || op == JR) ? 2'd2 : 2'd0;
      e.pcs = (op == JL) ? 2'd2 : (op == JR) ? 2'd3 : 2'd0;
    end
    return e;
  endfunction

  function automatic vec_t mkv(input logic [6:0] op, input logic [2:0] f3,
                               input logic az, input int wf, input int wm,
                               input int cyc, input int rw, input logic [1:0] pcs,
                               input logic [1:0] wbs, input int we, input logic asb);
    vec_t v;
    v.op = op; v.f3 = f3; v.az = az; v.wf = wf; v.wm = wm;
    v.e = '{cyc: cyc, pcw: 1, rw: rw, irw: 1, we: we, pcs: pcs, wbs: wbs,
            ill: 1'b0, to: 1'b0, asb: asb};
    return v;
  endfunction

  function automatic logic [10:0] strobes();
    return {mem_req, mem_we, mem_is_instr, ir_write, pc_write, pc_src,
            reg_write, wb_sel, alu_src_b};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Enter at posedge+1 in FETCH; leave at posedge+1 in next FETCH or HALT.
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic az, input int wf, input int wm, input exp_t e);
    int cyc, pcw, rw, irw, we, reqn, viol;
    logic [1:0] pcs, wbs;
    logic left, asb_seen, asb, p_req, p_rdy, p_we, p_ii;
    logic [31:0] ret0;
    state_e st;
    cyc = 0; pcw = 0; rw = 0; irw = 0; we = 0; reqn = 0; viol = 0;
    pcs = '0; wbs = '0; left = 0; asb_seen = 0; asb = 0;
    p_req = 0; p_rdy = 0; p_we = 0; p_ii = 0;
    ret0 = retired;
    while (1) begin
      st = state_e'(state);
      if (st == S_HALT || (st == S_FETCH && left)) break;
      if (cyc >= 300) begin
        chk({tag, " cycle bound"}, cyc, e.cyc);
        break;
      end
      if (st != S_FETCH) left = 1;
      opcode   = (st == S_FETCH || st == S_DECODE) ? op : 7'($urandom);
      func3    = (st == S_FETCH || st == S_DECODE) ? f3 : 3'($urandom);
      alu_zero = (st == S_EXECUTE) ? az : 1'($urandom);
      if (mem_req) begin
        reqn++;
        mem_ready = reqn > (mem_is_instr ? wf : wm);
      end else begin
        reqn = 0;
        mem_ready = 1'($urandom);
      end
      @(negedge clk);
      if (p_req && !p_rdy &&
          (!mem_req || mem_we !== p_we || mem_is_instr !== p_ii)) viol++;
      p_req = mem_req; p_rdy = mem_ready; p_we = mem_we; p_ii = mem_is_instr;
      if (pc_write) begin pcw++; pcs = pc_src; end
      if (reg_write) begin rw++; wbs = wb_sel; end
      irw += int'(ir_write);
      we  += int'(mem_we);
      if (st == S_EXECUTE) begin asb_seen = 1; asb = alu_src_b; end
      cyc++;
      @(posedge clk); #1;
    end
    chk({tag, " cycles"}, cyc, e.cyc);
    chk({tag, " pc_write"}, pcw, e.pcw);
    chk({tag, " reg_write"}, rw, e.rw);
    chk({tag, " ir_write"}, irw, e.irw);
    chk({tag, " mem_we cycles"}, we, e.we);
    if (e.pcw > 0) chk({tag, " pc_src"}, pcs, e.pcs);
    if (e.rw > 0)  chk({tag, " wb_sel"}, wbs, e.wbs);
    if (asb_seen)  chk({tag, " alu_src_b"}, asb, e.asb);
    chk({tag, " illegal"}, illegal, e.ill);
    chk({tag, " timeout"}, timeout, e.to);
    chk({tag, " retired delta"}, retired - ret0, e.pcw);
    chk({tag, " req stability"}, viol, 0);
    chk({tag, " end state"}, state, (e.ill || e.to) ? S_HALT : S_FETCH);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    reset = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk({tag, " rst state"}, state, S_IDLE);
    chk({tag, " rst strobes"}, strobes(), 0);
    chk({tag, " rst retired"}, retired, 0);
    chk({tag, " rst flags"}, {illegal, timeout}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk({tag, " idle after release"}, state, S_IDLE);
    chk({tag, " idle strobes"}, strobes(), 0);
    @(posedge clk); #1;
    chk({tag, " fetch after idle"}, state, S_FETCH);
    chk({tag, " fetch mem_req"}, {mem_req, mem_is_instr}, 2'b11);
  endtask

  task automatic hold_halt(input string tag, input int n);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      mem_ready = 1'($urandom);
      opcode = 7'($urandom);
      @(negedge clk);
      if (state !== S_HALT || strobes() !== 0) bad++;
      @(posedge clk); #1;
    end
    chk({tag, " halt quiet cycles"}, bad, 0);
  endtask

  vec_t vt [14];

  initial begin
    vt[0]  = mkv(R,  3'd0, 1'b0, 0, 0,  4, 1, 2'd0, 2'd0, 0, 1'b0);
    vt[1]  = mkv(LD, 3'd2, 1'b0, 3, 3, 11, 1, 2'd0, 2'd1, 0, 1'b1);
    vt[2]  = mkv(BR, 3'd0, 1'b1, 0, 0,  3, 0, 2'd1, 2'd0, 0, 1'b0);
    vt[3]  = mkv(BR, 3'd1, 1'b1, 0, 0,  3, 0, 2'd0, 2'd0, 0, 1'b0);
    vt[4]  = mkv(BR, 3'd0, 1'b0, 1, 0,  4, 0, 2'd0, 2'd0, 0, 1'b0);
    vt[5]  = mkv(BR, 3'd1, 1'b0, 0, 0,  3, 0, 2'd1, 2'd0, 0, 1'b0);
    vt[6]  = mkv(ST, 3'd2, 1'b0, 0, 2,  6, 0, 2'd0, 2'd0, 3, 1'b1);
    vt[7]  = mkv(JL, 3'd0, 1'b0, 1, 0,  5, 1, 2'd2, 2'd2, 0, 1'b1);
    vt[8]  = mkv(JR, 3'd0, 1'b0, 0, 0,  4, 1, 2'd3, 2'd2, 0, 1'b1);
    vt[9]  = mkv(LU, 3'd0, 1'b0, 0, 0,  4, 1, 2'd0, 2'd0, 0, 1'b1);
    vt[10] = mkv(I,  3'd0, 1'b0, 2, 0,  6, 1, 2'd0, 2'd0, 0, 1'b1);
    vt[11] = mkv(R,  3'd0, 1'b0, 7, 0, 11, 1, 2'd0, 2'd0, 0, 1'b0);
    vt[12] = mkv(LD, 3'd2, 1'b0, 0, 7, 12, 1, 2'd0, 2'd1, 0, 1'b1);
    vt[13] = mkv(ST, 3'd2, 1'b0, 7, 7, 18, 0, 2'd0, 2'd0, 8, 1'b1);

    do_reset("init");
    for (int i = 0; i < 14; i++) begin
      run_instr($sformatf("vec%0d", i), vt[i].op, vt[i].f3, vt[i].az,
                vt[i].wf, vt[i].wm, vt[i].e);
    end

    run_instr("illegal op", 7'h7F, 3'd0, 1'b0, 0, 0, model(7'h7F, 3'd0, 1'b0, 0, 0));
    hold_halt("illegal op", 20);
    do_reset("after illegal");

    run_instr("fetch timeout", R, 3'd0, 1'b0, 20, 0, model(R, 3'd0, 1'b0, 20, 0));
    hold_halt("fetch timeout", 5);
    do_reset("after fetch timeout");

    run_instr("mem timeout", ST, 3'd2, 1'b0, 1, 20, model(ST, 3'd2, 1'b0, 1, 20));
    do_reset("after mem timeout");

    run_instr("bad branch", BR, 3'd4, 1'b0, 0, 0, model(BR, 3'd4, 1'b0, 0, 0));
    do_reset("after bad branch");

    // JAL interrupted by reset while in WB.
    run_instr("pre-jal", R, 3'd0, 1'b0, 0, 0, model(R, 3'd0, 1'b0, 0, 0));
    begin
      int k;
      k = 0;
      opcode = JL;
      func3 = 3'd0;
      while (state_e'(state) != S_WB && k < 20) begin
        mem_ready = mem_req;
        @(posedge clk); #1;
        k++;
      end
      chk("jal reaches WB", state, S_WB);
      reset = 1'b1;
      #1;
      chk("jal rst strobes", {pc_write, reg_write}, 2'b00);
      @(posedge clk); #1;
      chk("jal rst retired", retired, 0);
      chk("jal rst state", state, S_IDLE);
      reset = 1'b0;
      @(negedge clk);
      chk("jal release idle", state, S_IDLE);
      chk("jal release strobes", strobes(), 0);
      @(posedge clk); #1;
      chk("jal release fetch", {state, mem_req}, {S_FETCH, 1'b1});
    end

    for (int n = 0; n < 300; n++) begin
      logic [6:0] o;
      logic [2:0] f;
      logic z;
      int wf, wm;
      if ($urandom_range(0, 9) == 0) begin
        do o = 7'($urandom); while (is_sup(o));
      end else begin
        o = ops[$urandom_range(0, 7)];
      end
      f  = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 1)) : 3'($urandom);
      z  = 1'($urandom);
      wf = ($urandom_range(0, 14) == 0) ? $urandom_range(7, 9) : $urandom_range(0, 3);
      wm = ($urandom_range(0, 14) == 0) ? $urandom_range(7, 9) : $urandom_range(0, 3);
      run_instr($sformatf("rnd%0d", n), o, f, z, wf, wm, model(o, f, z, wf, wm));
      if (state_e'(state) == S_HALT) do_reset($sformatf("rnd%0d reset", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
